// File: rtl/bit_queue_snap_if.sv
// Interface bundling the check-latch and snapshot-FIFO signals of bit_queue_snap.
// The master side drives the strobes and vectors; the slave side is the block itself.
interface bit_queue_snap_if #(
    parameter int BIT_WIDTH = 64,
    parameter int DEPTH     = 4
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ONES_W = $clog2(BIT_WIDTH + 1);

    logic                 chk_in;
    logic                 mode_in;
    logic [BIT_WIDTH-1:0] bit_in;
    logic [BIT_WIDTH-1:0] clr_in;
    logic [BIT_WIDTH-1:0] bit_out;
    logic [ONES_W-1:0]    ones_out;
    logic                 snap_in;
    logic                 rd_en;
    logic [BIT_WIDTH-1:0] snap_out;
    logic                 snap_valid;
    logic                 snap_full;
    logic [CNT_W-1:0]     snap_cnt;
    logic                 snap_ovf;
    logic                 ovf_clr_in;

    modport master (
        output chk_in, mode_in, bit_in, clr_in, snap_in, rd_en, ovf_clr_in,
        input  bit_out, ones_out, snap_out, snap_valid, snap_full, snap_cnt, snap_ovf
    );

    modport slave (
        input  chk_in, mode_in, bit_in, clr_in, snap_in, rd_en, ovf_clr_in,
        output bit_out, ones_out, snap_out, snap_valid, snap_full, snap_cnt, snap_ovf
    );
endinterface

// File: rtl/bit_queue_snap.sv
// Per-bit check latch (overwrite / sticky, synchronous per-bit clear) with a registered
// popcount and a first-word fall-through snapshot FIFO of the latch contents.
module bit_queue_snap #(
    parameter int BIT_WIDTH = 64,
    parameter int DEPTH     = 4
) (
    input logic             clk,
    input logic             rst,
    bit_queue_snap_if.slave bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ONES_W = $clog2(BIT_WIDTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    logic [BIT_WIDTH-1:0] bit_q;
    logic [BIT_WIDTH-1:0] latch_next;
    logic [ONES_W-1:0]    ones_q;
    logic [ONES_W-1:0]    ones_next;
    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_q;
    logic                 fifo_full;
    logic                 fifo_valid;
    logic                 do_push;
    logic                 do_pop;
    logic                 drop;

    // Clear is applied last so it overrides any same-cycle check update.
    assign latch_next = (bus.chk_in ? (bus.mode_in ? (bit_q | bus.bit_in) : bus.bit_in) : bit_q)
                        & ~bus.clr_in;

    always_comb begin
        ones_next = '0;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            ones_next = ones_next + ONES_W'(bit_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q  <= '0;
            ones_q <= '0;
        end else begin
            bit_q  <= latch_next;
            ones_q <= ones_next;
        end
    end

    assign fifo_full  = (cnt_q == CNT_W'(DEPTH));
    assign fifo_valid = (cnt_q != '0);
    // A pop frees the slot a full FIFO needs, so push-and-pop while full is not a drop.
    assign do_pop     = bus.rd_en & fifo_valid;
    assign do_push    = bus.snap_in & (~fifo_full | do_pop);
    assign drop       = bus.snap_in & fifo_full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bit_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr_in) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.bit_out    = bit_q;
    assign bus.ones_out   = ones_q;
    assign bus.snap_out   = fifo_valid ? mem[rd_ptr] : '0;
    assign bus.snap_valid = fifo_valid;
    assign bus.snap_full  = fifo_full;
    assign bus.snap_cnt   = cnt_q;
    assign bus.snap_ovf   = ovf_q;
endmodule

// File: tb/tb_bit_queue_snap.sv
// Self-checking bench for bit_queue_snap: directed steps plus random traffic against a
// queue-based reference model; a 1-bit-wide instance exercises the narrow latch path.
module tb_bit_queue_snap;
    localparam int BW  = 64;
    localparam int DP  = 4;
    localparam int BW1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    bit_queue_snap_if #(.BIT_WIDTH(BW),  .DEPTH(DP)) bus  ();
    bit_queue_snap_if #(.BIT_WIDTH(BW1), .DEPTH(DP)) bus1 ();

    bit_queue_snap #(.BIT_WIDTH(BW),  .DEPTH(DP)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    bit_queue_snap #(.BIT_WIDTH(BW1), .DEPTH(DP)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    logic [BW-1:0] m_bit;
    int            m_ones;
    logic [BW-1:0] m_q[$];
    logic          m_ovf;
    logic          m_bit1;
    int            m_ones1;
    logic [BW-1:0] vals[5];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [BW-1:0] exp_head;
        exp_head = (m_q.size() != 0) ? m_q[0] : '0;
        check_val("bit_out",     bus.bit_out,              m_bit);
        check_val("ones_out",    64'(bus.ones_out),        64'(m_ones));
        check_val("ones_bound",  64'(bus.ones_out <= BW),  64'd1);
        check_val("snap_cnt",    64'(bus.snap_cnt),        64'(m_q.size()));
        check_val("snap_valid",  64'(bus.snap_valid),      64'(m_q.size() != 0));
        check_val("snap_full",   64'(bus.snap_full),       64'(m_q.size() == DP));
        check_val("snap_out",    bus.snap_out,             exp_head);
        check_val("snap_ovf",    64'(bus.snap_ovf),        64'(m_ovf));
        check_val("bit_out_w1",  64'(bus1.bit_out),        64'(m_bit1));
        check_val("ones_out_w1", 64'(bus1.ones_out),       64'(m_ones1));
    endtask

    task automatic apply_stimulus(input logic chk, input logic mode, input logic [BW-1:0] b,
                                  input logic [BW-1:0] c, input logic snap, input logic rd,
                                  input logic oclr);
        bus.chk_in     = chk;
        bus.mode_in    = mode;
        bus.bit_in     = b;
        bus.clr_in     = c;
        bus.snap_in    = snap;
        bus.rd_en      = rd;
        bus.ovf_clr_in = oclr;
    endtask

    // One clock: model the edge from pre-edge state and inputs, then compare.
    task automatic cycle();
        logic [BW-1:0] nb;
        logic [BW-1:0] snap_val;
        logic          nb1;
        int            n_ones;
        int            n_ones1;
        logic          pop;
        logic          push;
        logic          drop;
        bus1.chk_in  = 1'($urandom);
        bus1.mode_in = 1'($urandom);
        bus1.bit_in  = 1'($urandom);
        bus1.clr_in  = 1'(($urandom % 4) == 0);
        for (int i = 0; i < BW; i++) begin
            if (bus.clr_in[i])     nb[i] = 1'b0;
            else if (bus.chk_in)   nb[i] = bus.mode_in ? (m_bit[i] | bus.bit_in[i]) : bus.bit_in[i];
            else                   nb[i] = m_bit[i];
        end
        if (bus1.clr_in[0])      nb1 = 1'b0;
        else if (bus1.chk_in)    nb1 = bus1.mode_in ? (m_bit1 | bus1.bit_in[0]) : bus1.bit_in[0];
        else                     nb1 = m_bit1;
        n_ones   = $countones(m_bit);
        n_ones1  = m_bit1 ? 1 : 0;
        snap_val = m_bit;
        pop      = bus.rd_en && (m_q.size() > 0);
        push     = bus.snap_in && ((m_q.size() < DP) || pop);
        drop     = bus.snap_in && !push;
        @(posedge clk);
        m_bit   = nb;
        m_ones  = n_ones;
        m_bit1  = nb1;
        m_ones1 = n_ones1;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(snap_val);
        if (drop)                m_ovf = 1'b1;
        else if (bus.ovf_clr_in) m_ovf = 1'b0;
        #1;
        check_output();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_bit   = '0;
        m_ones  = 0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_bit1  = 1'b0;
        m_ones1 = 0;
        check_output();
        @(posedge clk);
        #1;
        check_output();
        rst = 1'b0;
    endtask

    initial begin
        bus1.snap_in    = 1'b0;
        bus1.rd_en      = 1'b0;
        bus1.ovf_clr_in = 1'b0;
        bus1.chk_in     = 1'b0;
        bus1.mode_in    = 1'b0;
        bus1.bit_in     = '0;
        bus1.clr_in     = '0;
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        do_reset();

        // Some traffic, then reset mid-run.
        repeat (6) begin
            apply_stimulus(1'($urandom), 1'($urandom), {$urandom, $urandom}, '0,
                           1'($urandom), 1'b0, 1'b0);
            cycle();
        end
        do_reset();

        // Overwrite mode and popcount lag.
        apply_stimulus(1'b1, 1'b0, 64'hF0, '0, 1'b0, 1'b0, 1'b0); cycle();
        check_val("ovw_f0", bus.bit_out, 64'hF0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0); cycle();
        check_val("ones_4", 64'(bus.ones_out), 64'd4);
        apply_stimulus(1'b1, 1'b0, 64'h0F, '0, 1'b0, 1'b0, 1'b0); cycle();
        check_val("ovw_0f", bus.bit_out, 64'h0F);

        // Sticky accumulate and clear-beats-check.
        apply_stimulus(1'b1, 1'b1, 64'h01, '0, 1'b0, 1'b0, 1'b0); cycle();
        apply_stimulus(1'b1, 1'b1, 64'h80, '0, 1'b0, 1'b0, 1'b0); cycle();
        check_val("sticky_81", bus.bit_out, 64'h8F);
        apply_stimulus(1'b1, 1'b0, 64'h01, '0, 1'b0, 1'b0, 1'b0); cycle();
        apply_stimulus(1'b1, 1'b1, 64'h80, '0, 1'b0, 1'b0, 1'b0); cycle();
        check_val("sticky_81b", bus.bit_out, 64'h81);
        apply_stimulus(1'b1, 1'b1, 64'hFF, 64'h01, 1'b0, 1'b0, 1'b0); cycle();
        check_val("clr_prio", bus.bit_out, 64'hFE);

        // Snapshot captures the pre-edge latch value.
        apply_stimulus(1'b1, 1'b0, 64'h81, '0, 1'b0, 1'b0, 1'b0); cycle();
        apply_stimulus(1'b1, 1'b0, 64'h00, '0, 1'b1, 1'b0, 1'b0); cycle();
        check_val("snap_head_81", bus.snap_out, 64'h81);
        check_val("snap_valid_1", 64'(bus.snap_valid), 64'd1);
        check_val("snap_cnt_1",   64'(bus.snap_cnt), 64'd1);
        check_val("snap_bit_0",   bus.bit_out, 64'h0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();

        // Fill past capacity.
        for (int k = 0; k < 5; k++) vals[k] = {$urandom, 32'(k + 1)};
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 1'b0, vals[k], '0, 1'b0, 1'b0, 1'b0); cycle();
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0); cycle();
        end
        check_val("fill_full", 64'(bus.snap_full), 64'd1);
        check_val("fill_cnt",  64'(bus.snap_cnt), 64'd4);
        check_val("fill_ovf",  64'(bus.snap_ovf), 64'd1);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1); cycle();
        check_val("ovf_set_wins", 64'(bus.snap_ovf), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check_val("fill_order", bus.snap_out, vals[k]);
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
        end
        check_val("drain_cnt",  64'(bus.snap_cnt), 64'd0);
        check_val("ovf_sticky", 64'(bus.snap_ovf), 64'd1);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1); cycle();
        check_val("ovf_cleared", 64'(bus.snap_ovf), 64'd0);

        // Push and pop together while full, then while empty.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, 1'b0, vals[k], '0, 1'b0, 1'b0, 1'b0); cycle();
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0); cycle();
        end
        apply_stimulus(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, '0, 1'b0, 1'b0, 1'b0); cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0); cycle();
        check_val("pp_full_cnt", 64'(bus.snap_cnt), 64'd4);
        check_val("pp_full_ovf", 64'(bus.snap_ovf), 64'd0);
        for (int k = 1; k < 4; k++) begin
            check_val("pp_order", bus.snap_out, vals[k]);
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
        end
        check_val("pp_last", bus.snap_out, 64'hDEAD_BEEF_0000_0001);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0); cycle();
        check_val("pp_empty_cnt",  64'(bus.snap_cnt), 64'd1);
        check_val("pp_empty_head", bus.snap_out, 64'hDEAD_BEEF_0000_0001);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
        check_val("pop_empty_cnt",   64'(bus.snap_cnt), 64'd0);
        check_val("pop_empty_valid", 64'(bus.snap_valid), 64'd0);

        // Random interleaved traffic through many pointer wraps.
        repeat (300) begin
            apply_stimulus(1'($urandom), 1'($urandom), {$urandom, $urandom},
                           (($urandom % 4) == 0) ? {$urandom, $urandom} : 64'h0,
                           1'($urandom), 1'($urandom), 1'(($urandom % 8) == 0));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
